if_fetch_unit: RTL and testbench

//  Instruction-fetch stage feeding the IF/ID pipeline register.
//  - Owns the PC and issues one request at a time to instruction memory over a req/gnt/rvalid handshake.
//  - Buffers the returned word and presents pc+4/instr to IF/ID; advances only when the HDU allows (pc_write).
//  - Applies taken-branch/jump redirects, discarding any stale in-flight or buffered fetch.

---
 rtl/if_fetch_unit_if.sv | 31 +++
 rtl/if_fetch_unit.sv | 105 ++++++++++
 tb/tb_if_fetch_unit.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/if_fetch_unit_if.sv
// Fetch-stage bundle: instruction-memory req/gnt/rvalid bus, HDU/redirect controls,
// and the IF/ID-facing instruction outputs.
interface if_fetch_unit_if #(
   parameter int XLEN = 32
);
   logic            pc_write;
   logic            redirect;
   logic [XLEN-1:0] redirect_pc;
   logic            imem_req;
   logic [XLEN-1:0] imem_addr;
   logic            imem_gnt;
   logic            imem_rvalid;
   logic [31:0]     imem_rdata;
   logic            if_valid;
   logic [31:0]     if_instr;
   logic [XLEN-1:0] if_pc4;

   modport master (
      input  pc_write, redirect, redirect_pc,
      input  imem_gnt, imem_rvalid, imem_rdata,
      output imem_req, imem_addr,
      output if_valid, if_instr, if_pc4
   );

   modport slave (
      output pc_write, redirect, redirect_pc,
      output imem_gnt, imem_rvalid, imem_rdata,
      input  imem_req, imem_addr,
      input  if_valid, if_instr, if_pc4
   );
endinterface

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, keeps one memory request in flight at a time,
// buffers the returned word for IF/ID and handles branch/jump redirects.
module if_fetch_unit #(
   parameter int              XLEN     = 32,
   parameter logic [XLEN-1:0] RESET_PC = '0
) (
   input logic              clk,
   input logic              rst,
   if_fetch_unit_if.master  bus
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2,
      HOLD = 2'd3
   } state_t;

   state_t          state_q;
   logic [XLEN-1:0] pc_q;
   logic [XLEN-1:0] pc4_q;
   logic            drop_q;
   logic            req_q;
   logic            valid_q;
   logic [31:0]     instr_q;

   logic [XLEN-1:0] target_d;
   logic [XLEN-1:0] pc_inc_d;

   assign target_d = bus.redirect_pc & ~(XLEN'(3));
   assign pc_inc_d = pc_q + XLEN'(4);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         pc_q    <= RESET_PC;
         pc4_q   <= '0;
         drop_q  <= 1'b0;
         req_q   <= 1'b0;
         valid_q <= 1'b0;
         instr_q <= 32'h0000_0000;
      end else begin
         case (state_q)
            IDLE: begin
               if (bus.redirect) pc_q <= target_d;
               state_q <= REQ;
               req_q   <= 1'b1;
            end
            REQ: begin
               if (bus.redirect) pc_q <= target_d;
               if (bus.imem_gnt) begin
                  // A redirect in the grant cycle makes the word now in flight stale.
                  req_q   <= 1'b0;
                  drop_q  <= bus.redirect;
                  state_q <= WAIT;
               end
            end
            WAIT: begin
               if (bus.redirect) begin
                  pc_q <= target_d;
                  if (bus.imem_rvalid) begin
                     drop_q  <= 1'b0;
                     req_q   <= 1'b1;
                     state_q <= REQ;
                  end else begin
                     drop_q <= 1'b1;
                  end
               end else if (bus.imem_rvalid) begin
                  if (drop_q) begin
                     drop_q  <= 1'b0;
                     req_q   <= 1'b1;
                     state_q <= REQ;
                  end else begin
                     instr_q <= bus.imem_rdata;
                     pc4_q   <= pc_inc_d;
                     valid_q <= 1'b1;
                     state_q <= HOLD;
                  end
               end
            end
            HOLD: begin
               if (bus.redirect || bus.pc_write) begin
                  pc_q    <= bus.redirect ? target_d : pc_inc_d;
                  valid_q <= 1'b0;
                  instr_q <= 32'h0000_0000;
                  pc4_q   <= '0;
                  req_q   <= 1'b1;
                  state_q <= REQ;
               end
            end
            default: begin
               state_q <= IDLE;
               req_q   <= 1'b0;
            end
         endcase
      end
   end

   assign bus.imem_req  = req_q;
   assign bus.imem_addr = pc_q;
   assign bus.if_valid  = valid_q;
   assign bus.if_instr  = instr_q;
   assign bus.if_pc4    = pc4_q;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed and randomized checks of if_fetch_unit against a transaction-level fetch model.
module tb_if_fetch_unit;
   localparam int XLEN = 32;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   if_fetch_unit_if #(.XLEN(XLEN)) bus ();

   if_fetch_unit #(.XLEN(XLEN), .RESET_PC('0)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_tests = 0;
   int n_fail  = 0;

   // memory responder state
   logic        pend       = 1'b0;
   logic        pend_stale = 1'b0;
   logic [31:0] pend_addr  = '0;
   int          wait_cnt   = 0;
   int          gnt_block  = 0;
   int          lat_cfg    = 1;
   bit          rand_mem   = 1'b0;
   int          n_gnt      = 0;
   int          n_consume  = 0;

   // architectural expectation: which PC should be fetched and what IF/ID should see
   logic [31:0] exp_pc    = '0;
   logic        exp_valid = 1'b0;
   logic [31:0] exp_instr = '0;
   logic [31:0] exp_pc4   = '0;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      if (a == 32'h0000_0004) return 32'h2001_0005;
      return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // One clock cycle: memory answers, model advances, DUT outputs compared after the edge.
   task automatic step(input logic pw, input logic rd, input logic [31:0] rpc);
      logic        gnt;
      logic        rv;
      logic        accept;
      logic        was_valid;
      logic [31:0] rdata;
      gnt    = bus.imem_req && (rand_mem ? ($urandom_range(0, 2) != 0) : (gnt_block == 0));
      rv     = pend && (wait_cnt == 0);
      rdata  = pend ? mem_word(pend_addr) : $urandom();
      if (!pend && rand_mem && ($urandom_range(0, 7) == 0)) rv = 1'b1;
      bus.pc_write    = pw;
      bus.redirect    = rd;
      bus.redirect_pc = rpc;
      bus.imem_gnt    = gnt;
      bus.imem_rvalid = rv;
      bus.imem_rdata  = rdata;

      was_valid = exp_valid;
      accept    = 1'b0;
      if (pend && rv) begin
         accept     = !pend_stale && !rd;
         pend       = 1'b0;
         pend_stale = 1'b0;
      end else if (pend && wait_cnt > 0) begin
         wait_cnt--;
      end
      if (rd) begin
         exp_pc    = rpc & 32'hFFFF_FFFC;
         exp_valid = 1'b0;
         if (pend) pend_stale = 1'b1;
      end else if (was_valid && pw) begin
         exp_pc    = exp_pc + 32'd4;
         exp_valid = 1'b0;
         n_consume++;
      end
      if (accept) begin
         exp_valid = 1'b1;
         exp_instr = mem_word(exp_pc);
         exp_pc4   = exp_pc + 32'd4;
      end
      if (!rand_mem && bus.imem_req && !gnt && gnt_block > 0) gnt_block--;
      if (gnt) begin
         n_gnt++;
         pend       = 1'b1;
         pend_stale = rd;
         pend_addr  = bus.imem_addr;
         wait_cnt   = (rand_mem ? $urandom_range(1, 3) : lat_cfg) - 1;
      end

      @(posedge clk);
      #1;
      chk("if_valid", {31'b0, bus.if_valid}, {31'b0, exp_valid});
      chk("if_instr", bus.if_instr, exp_valid ? exp_instr : 32'h0);
      chk("if_pc4", bus.if_pc4, exp_valid ? exp_pc4 : 32'h0);
      if (bus.imem_req) chk("imem_addr", bus.imem_addr, exp_pc);
      if (pend) chk("req_while_outstanding", {31'b0, bus.imem_req}, 32'd0);
   endtask

   task automatic apply_reset();
      #2 rst = 1'b1;
      bus.imem_gnt = 1'b0;
      bus.pc_write = 1'b0;
      bus.redirect = 1'b0;
      #1;
      chk("rst_req", {31'b0, bus.imem_req}, 32'd0);
      chk("rst_valid", {31'b0, bus.if_valid}, 32'd0);
      chk("rst_instr", bus.if_instr, 32'h0);
      chk("rst_pc4", bus.if_pc4, 32'h0);
      chk("rst_addr", bus.imem_addr, 32'h0);
      bus.imem_rvalid = 1'b1;
      bus.imem_rdata  = 32'hDEAD_BEEF;
      @(posedge clk);
      #2 rst = 1'b0;
      pend = 1'b0; pend_stale = 1'b0; wait_cnt = 0; gnt_block = 0;
      exp_pc = '0; exp_valid = 1'b0;
      @(posedge clk);
      #1;
      bus.imem_rvalid = 1'b0;
      chk("post_rst_req", {31'b0, bus.imem_req}, 32'd1);
      chk("post_rst_addr", bus.imem_addr, 32'h0);
      chk("post_rst_valid", {31'b0, bus.if_valid}, 32'd0);
   endtask

   task automatic wait_valid(input string tag, input int budget);
      int k = 0;
      while (!bus.if_valid && k < budget) begin
         step(1'b0, 1'b0, 32'h0);
         k++;
      end
      chk(tag, {31'b0, bus.if_valid}, 32'd1);
   endtask

   task automatic wait_req(input string tag, input int budget);
      int k = 0;
      while (!bus.imem_req && k < budget) begin
         step(1'b0, 1'b0, 32'h0);
         k++;
      end
      chk(tag, {31'b0, bus.imem_req}, 32'd1);
   endtask

   initial begin
      int g0;
      bus.pc_write    = 1'b0;
      bus.redirect    = 1'b0;
      bus.redirect_pc = '0;
      bus.imem_gnt    = 1'b0;
      bus.imem_rvalid = 1'b0;
      bus.imem_rdata  = '0;

      apply_reset();

      // sequential fetch, immediate grant, one-cycle latency
      step(1'b0, 1'b0, 32'h0);
      chk("t1_wait_req", {31'b0, bus.imem_req}, 32'd0);
      step(1'b0, 1'b0, 32'h0);
      chk("t1_valid", {31'b0, bus.if_valid}, 32'd1);
      chk("t1_pc4_4", bus.if_pc4, 32'h4);
      step(1'b1, 1'b0, 32'h0);
      chk("t1_addr4", bus.imem_addr, 32'h4);
      chk("t1_req4", {31'b0, bus.imem_req}, 32'd1);
      step(1'b0, 1'b0, 32'h0);
      step(1'b0, 1'b0, 32'h0);
      chk("t2_instr", bus.if_instr, 32'h2001_0005);

      // stall in HOLD
      for (int i = 0; i < 5; i++) begin
         step(1'b0, 1'b0, 32'h0);
         chk("t2_hold_instr", bus.if_instr, 32'h2001_0005);
         chk("t2_hold_pc4", bus.if_pc4, 32'h8);
         chk("t2_no_req", {31'b0, bus.imem_req}, 32'd0);
      end
      step(1'b1, 1'b0, 32'h0);
      chk("t2_next_addr", bus.imem_addr, 32'h8);
      step(1'b0, 1'b0, 32'h0);
      step(1'b0, 1'b0, 32'h0);
      chk("t4_pc4_12", bus.if_pc4, 32'hC);

      // redirect beats pc_write in HOLD
      step(1'b1, 1'b1, 32'h0000_0200);
      chk("t4_valid", {31'b0, bus.if_valid}, 32'd0);
      chk("t4_addr", bus.imem_addr, 32'h200);

      // redirect while the old fetch is outstanding
      lat_cfg = 3;
      step(1'b0, 1'b0, 32'h0);
      step(1'b0, 1'b1, 32'h0000_0103);
      wait_req("t3_req", 8);
      chk("t3_addr", bus.imem_addr, 32'h100);
      lat_cfg = 1;
      wait_valid("t3_fetch", 8);
      chk("t3_instr", bus.if_instr, mem_word(32'h100));
      chk("t3_pc4", bus.if_pc4, 32'h104);

      // grant withheld, redirect mid-request
      step(1'b1, 1'b0, 32'h0);
      gnt_block = 3;
      g0 = n_gnt;
      step(1'b0, 1'b0, 32'h0);
      step(1'b0, 1'b1, 32'h0000_0040);
      chk("t5_req_held", {31'b0, bus.imem_req}, 32'd1);
      chk("t5_addr", bus.imem_addr, 32'h40);
      wait_valid("t5_fetch", 10);
      chk("t5_one_gnt", 32'(n_gnt - g0), 32'd1);
      chk("t5_instr", bus.if_instr, mem_word(32'h40));

      // wrap-around, then reset with a fetch in flight
      step(1'b0, 1'b1, 32'hFFFF_FFFC);
      wait_valid("t6_fetch", 8);
      chk("t6_pc4_wrap", bus.if_pc4, 32'h0);
      step(1'b1, 1'b0, 32'h0);
      chk("t6_addr0", bus.imem_addr, 32'h0);
      lat_cfg = 3;
      step(1'b0, 1'b1, 32'h0000_0300);
      chk("t6_in_wait", bus.imem_addr, 32'h300);
      apply_reset();
      lat_cfg = 1;
      wait_valid("t6_after_rst", 8);
      chk("t6_after_rst_pc4", bus.if_pc4, 32'h4);

      // randomized traffic
      rand_mem  = 1'b1;
      n_consume = 0;
      for (int i = 0; i < 3000; i++) begin
         if (i == 1500) apply_reset();
         step(1'($urandom_range(0, 1)), ($urandom_range(0, 9) == 0), $urandom());
      end
      chk("rand_progress", {31'b0, (n_consume > 100)}, 32'd1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
